// File: rtl/mem_arbiter.sv
// Shares one 8-bit single-port memory between the CPU core and a DMA/video requester.
// Every access runs ARB -> ACCESS x(WAIT_CYCLES+1) -> COMPLETE with registered memory-side outputs.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DMA_BURST   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_locked,
  input  logic        dma_req,
  input  logic [19:0] dma_address,
  input  logic        dma_we,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic            owner_dma_q, owner_dma_d;
  logic            last_dma_q, last_dma_d;
  logic [AW-1:0]   mem_address_q, mem_address_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   cpu_in_q, cpu_in_d;
  logic            cpu_locked_q, cpu_locked_d;
  logic            dma_ack_q, dma_ack_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;

  logic            dma_pref_c;
  logic            grant_dma_c;
  logic            grant_cpu_c;

  // DMA keeps the bus after a CPU slot, or while its burst allowance lasts.
  assign dma_pref_c  = !last_dma_q || (burst_q < CW'(DMA_BURST));
  assign grant_dma_c = dma_req && (!cpu_en || dma_pref_c);
  assign grant_cpu_c = cpu_en && !grant_dma_c;

  // State register. Reset counts the burst as spent so the CPU takes the first contested slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ARB;
      cnt_q         <= '0;
      burst_q       <= CW'(DMA_BURST);
      owner_dma_q   <= 1'b0;
      last_dma_q    <= 1'b1;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      cpu_in_q      <= '0;
      cpu_locked_q  <= 1'b0;
      dma_ack_q     <= 1'b0;
      dma_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      burst_q       <= burst_d;
      owner_dma_q   <= owner_dma_d;
      last_dma_q    <= last_dma_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      cpu_in_q      <= cpu_in_d;
      cpu_locked_q  <= cpu_locked_d;
      dma_ack_q     <= dma_ack_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    burst_d       = burst_q;
    owner_dma_d   = owner_dma_q;
    last_dma_d    = last_dma_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = mem_we_q;
    cpu_in_d      = cpu_in_q;
    cpu_locked_d  = 1'b0;
    dma_ack_d     = 1'b0;
    dma_rdata_d   = dma_rdata_q;

    unique case (state_q)
      ARB: begin
        mem_we_d = 1'b0;
        if (grant_dma_c) begin
          mem_address_d = dma_address;
          mem_wdata_d   = dma_wdata;
          mem_we_d      = dma_we;
          owner_dma_d   = 1'b1;
          burst_d       = (burst_q == {CW{1'b1}}) ? burst_q : burst_q + CW'(1);
          cnt_d         = CW'(WAIT_CYCLES);
          state_d       = ACCESS;
        end else if (grant_cpu_c) begin
          mem_address_d = cpu_address;
          mem_wdata_d   = cpu_out;
          mem_we_d      = cpu_we;
          owner_dma_d   = 1'b0;
          burst_d       = '0;
          cnt_d         = CW'(WAIT_CYCLES);
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Write strobe ends with the data phase so it spans exactly WAIT_CYCLES+1 cycles.
          mem_we_d = 1'b0;
          if (owner_dma_q) begin
            dma_rdata_d = mem_rdata;
            dma_ack_d   = 1'b1;
          end else begin
            cpu_in_d     = mem_rdata;
            cpu_locked_d = 1'b1;
          end
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      COMPLETE: begin
        mem_we_d   = 1'b0;
        last_dma_d = owner_dma_q;
        state_d    = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  assign cpu_in      = cpu_in_q;
  assign cpu_locked  = cpu_locked_q;
  assign dma_ack     = dma_ack_q;
  assign dma_rdata   = dma_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic        cpu_en = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [19:0] cpu_address = '0, dma_address = '0;
  logic [7:0]  cpu_out = '0, dma_wdata = '0;
  logic [7:0]  cpu_in, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_locked, dma_ack, mem_we;
  logic [19:0] mem_address;

  logic        cpu_en2 = 1'b0, dma_req2 = 1'b0;
  logic [19:0] cpu_address2 = 20'h00AAA, dma_address2 = 20'h00BBB;
  logic [7:0]  cpu_out2 = 8'h33, dma_wdata2 = 8'h44;
  logic [7:0]  mem_rdata2 = 8'h00;
  logic [7:0]  cpu_in2, dma_rdata2, mem_wdata2;
  logic        cpu_locked2, dma_ack2, mem_we2;
  logic [19:0] mem_address2;

  mem_arbiter #(.WAIT_CYCLES(1), .DMA_BURST(1)) u_dut (
    .clock(clock), .reset(reset), .cpu_en(cpu_en), .cpu_address(cpu_address),
    .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_in(cpu_in), .cpu_locked(cpu_locked),
    .dma_req(dma_req), .dma_address(dma_address), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));

  mem_arbiter #(.WAIT_CYCLES(0), .DMA_BURST(3)) u_dut3 (
    .clock(clock), .reset(reset), .cpu_en(cpu_en2), .cpu_address(cpu_address2),
    .cpu_out(cpu_out2), .cpu_we(1'b0), .cpu_in(cpu_in2), .cpu_locked(cpu_locked2),
    .dma_req(dma_req2), .dma_address(dma_address2), .dma_we(1'b0), .dma_wdata(dma_wdata2),
    .dma_ack(dma_ack2), .dma_rdata(dma_rdata2), .mem_address(mem_address2),
    .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2));

  // Synchronous memory model: read data one cycle after address, well inside WAIT_CYCLES+1.
  logic [7:0] mem [0:4095];
  always @(posedge clock) begin
    if (reset) begin
      mem[12'hFF0] <= 8'hEA;
      mem[12'h345] <= 8'h5A;
      mem[12'h400] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_address[11:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_address[11:0]];
  end

  typedef struct {
    bit         dma;
    bit         chk;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  logic [19:0] wr_addr_exp = '0;
  logic [7:0]  wr_data_exp = '0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit dma, input bit chk_d, input logic [7:0] d, input int c);
    exp_t e;
    e.dma = dma; e.chk = chk_d; e.data = d; e.cyc = c;
    return e;
  endfunction

  // Monitor: pops an expectation whenever either instance completes a slot.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (cpu_locked || dma_ack) begin
        chk("locked_ack_exclusive", 32'(cpu_locked & dma_ack), 32'd0);
        if (q1.size() == 0) begin
          chk("unexpected_grant", {30'd0, dma_ack, cpu_locked}, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("owner", 32'(dma_ack), 32'(e.dma));
          if (e.chk) chk("rdata", 32'(dma_ack ? dma_rdata : cpu_in), 32'(e.data));
          if (e.cyc != 0) chk("complete_cycle", cyc, e.cyc);
        end
      end
      if (mem_we) begin
        we_cnt = we_cnt + 1;
        chk("wr_addr", 32'(mem_address), 32'(wr_addr_exp));
        chk("wr_data", 32'(mem_wdata), 32'(wr_data_exp));
      end
      if (cpu_locked2 || dma_ack2 || mem_we2) begin
        if (q2.size() == 0) begin
          chk("unexpected_grant2", {29'd0, mem_we2, dma_ack2, cpu_locked2}, 32'd0);
        end else begin
          e = q2.pop_front();
          chk("owner2", 32'(dma_ack2), 32'(e.dma));
          chk("mem_we2", 32'(mem_we2), 32'd0);
          chk("addr2", 32'(mem_address2), e.dma ? 32'h00BBB : 32'h00AAA);
          chk("wdata2", 32'(mem_wdata2), e.dma ? 32'h44 : 32'h33);
          chk("rdata2", 32'(e.dma ? dma_rdata2 : cpu_in2), 32'd0);
        end
      end
    end
  end

  task automatic wait_empty(input bit second, input int maxc);
    int n = 0;
    do begin
      @(posedge clock);
      #2;
      n++;
    end while (((second ? q2.size() : q1.size()) != 0) && n < maxc);
    if ((second ? q2.size() : q1.size()) != 0) begin
      chk("wait_timeout", second ? q2.size() : q1.size(), 32'd0);
      if (second) q2.delete(); else q1.delete();
    end
  endtask

  initial begin
    int base;
    #1 reset = 1'b1;
    #2;
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_locked", 32'(cpu_locked), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_cpu_in", 32'(cpu_in), 32'd0);

    // CPU-only stream of reads from FFFF0, one step every 4 cycles.
    cpu_en = 1'b1; cpu_address = 20'hFFFF0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    base = cyc;
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, base + 3));
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, base + 7));
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, base + 11));
    @(negedge clock);
    chk("first_addr", 32'(mem_address), 32'hFFFF0);
    wait_empty(1'b0, 40);
    cpu_en = 1'b0;

    // DMA-only read of 12345.
    dma_address = 20'h12345; dma_req = 1'b1;
    q1.push_back(mk(1'b1, 1'b1, 8'h5A, 0));
    wait_empty(1'b0, 20);
    dma_req = 1'b0;

    // Contention with DMA_BURST=1: last owner DMA, burst used -> CPU,DMA,CPU,DMA.
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, 0));
    q1.push_back(mk(1'b1, 1'b1, 8'h5A, 0));
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, 0));
    q1.push_back(mk(1'b1, 1'b1, 8'h5A, 0));
    cpu_en = 1'b1; dma_req = 1'b1;
    wait_empty(1'b0, 60);
    cpu_en = 1'b0; dma_req = 1'b0;

    // CPU write of 77 to 00400; late changes on the CPU bus must be ignored.
    we_cnt = 0; wr_addr_exp = 20'h00400; wr_data_exp = 8'h77;
    q1.push_back(mk(1'b0, 1'b0, 8'h00, 0));
    cpu_address = 20'h00400; cpu_out = 8'h77; cpu_we = 1'b1; cpu_en = 1'b1;
    @(posedge clock);
    #2;
    cpu_address = 20'h00555; cpu_out = 8'h11;
    wait_empty(1'b0, 20);
    cpu_en = 1'b0; cpu_we = 1'b0;
    chk("we_cycles", we_cnt, 32'd2);
    q1.push_back(mk(1'b1, 1'b1, 8'h77, 0));
    dma_address = 20'h00400; dma_req = 1'b1;
    wait_empty(1'b0, 20);
    dma_req = 1'b0;

    // Reset in the middle of a DMA access.
    dma_address = 20'h12345; dma_req = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_address", 32'(mem_address), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_dma_ack", 32'(dma_ack), 32'd0);
    chk("abort_dma_rdata", 32'(dma_rdata), 32'd0);
    chk("abort_cpu_in", 32'(cpu_in), 32'd0);
    chk("abort_cpu_locked", 32'(cpu_locked), 32'd0);
    cpu_address = 20'hFFFF0; cpu_en = 1'b1;
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, 0));
    q1.push_back(mk(1'b1, 1'b1, 8'h5A, 0));
    @(negedge clock);
    reset = 1'b0;
    wait_empty(1'b0, 30);
    cpu_en = 1'b0; dma_req = 1'b0;

    // DMA request pulsed only during a CPU ACCESS is never granted.
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, 0));
    q1.push_back(mk(1'b0, 1'b1, 8'hEA, 0));
    cpu_en = 1'b1;
    @(posedge clock);
    #2 dma_req = 1'b1;
    @(posedge clock);
    #2 dma_req = 1'b0;
    wait_empty(1'b0, 30);
    cpu_en = 1'b0;

    // DMA_BURST=3 instance: CPU,DMA,DMA,DMA,CPU,...
    for (int i = 0; i < 9; i++) q2.push_back(mk((i % 4) != 0, 1'b0, 8'h00, 0));
    cpu_en2 = 1'b1; dma_req2 = 1'b1;
    wait_empty(1'b1, 60);
    cpu_en2 = 1'b0; dma_req2 = 1'b0;

    repeat (10) @(posedge clock);
    #2;
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
